// File: rtl/store_buffer_ordered_pkg.sv
// rtl/store_buffer_ordered_pkg.sv - shared types, widths and address helpers for the ordered store buffer
package store_buffer_ordered_pkg;

    localparam int SB_NUM_ENTRIES = 4;
    localparam int SB_ADDR_WIDTH  = 32;
    localparam int SB_DATA_WIDTH  = 32;
    localparam int SB_BYTES       = SB_DATA_WIDTH / 8;
    localparam int SB_OFF         = $clog2(SB_BYTES);

    typedef struct packed {
        logic [SB_ADDR_WIDTH-1:0] addr;
        logic [SB_DATA_WIDTH-1:0] data;
        logic [SB_BYTES-1:0]      be;
    } store_sb_entry_t;

    function automatic logic sb_same_word(input logic [SB_ADDR_WIDTH-1:0] a,
                                          input logic [SB_ADDR_WIDTH-1:0] b);
        return (a >> SB_OFF) == (b >> SB_OFF);
    endfunction

    function automatic logic [SB_ADDR_WIDTH-1:0] sb_word_align(input logic [SB_ADDR_WIDTH-1:0] a);
        return (a >> SB_OFF) << SB_OFF;
    endfunction

endpackage

// File: rtl/store_sb_fwd_select.sv
// rtl/store_sb_fwd_select.sv - per-lane youngest-match byte selection for load forwarding
module store_sb_fwd_select
    import store_buffer_ordered_pkg::*;
#(
    parameter int NUM_ENTRIES = SB_NUM_ENTRIES,
    localparam int PW = $clog2(NUM_ENTRIES)
) (
    input  store_sb_entry_t          entries_i [NUM_ENTRIES],
    input  logic [NUM_ENTRIES-1:0]   valid_i,
    input  logic [PW-1:0]            head_i,
    input  logic [SB_ADDR_WIDTH-1:0] addr_i,
    output logic [SB_DATA_WIDTH-1:0] data_o,
    output logic [SB_BYTES-1:0]      fwd_be_o
);

    // Walk oldest to youngest so later matches overwrite earlier ones per lane.
    always_comb begin
        logic [PW-1:0] idx;
        data_o   = '0;
        fwd_be_o = '0;
        idx      = head_i;
        for (int k = 0; k < NUM_ENTRIES; k++) begin
            idx = head_i + PW'(k);
            if (valid_i[idx] && sb_same_word(entries_i[idx].addr, addr_i)) begin
                for (int b = 0; b < SB_BYTES; b++) begin
                    if (entries_i[idx].be[b]) begin
                        data_o[8*b +: 8] = entries_i[idx].data[8*b +: 8];
                        fwd_be_o[b]      = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer_ordered.sv
// rtl/store_buffer_ordered.sv - in-order store buffer with cache drain, load forwarding and coalescing
module store_buffer_ordered
    import store_buffer_ordered_pkg::*;
#(
    parameter int NUM_ENTRIES = SB_NUM_ENTRIES,
    parameter int ADDR_WIDTH  = SB_ADDR_WIDTH,
    parameter int DATA_WIDTH  = SB_DATA_WIDTH,
    parameter bit COALESCE_EN = 1'b1,
    localparam int BYTES = DATA_WIDTH / 8,
    localparam int PW    = $clog2(NUM_ENTRIES),
    localparam int CW    = PW + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  push_valid_i,
    output logic                  push_ready_o,
    input  logic [ADDR_WIDTH-1:0] push_addr_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic [BYTES-1:0]      push_be_i,
    output logic                  drain_valid_o,
    input  logic                  drain_ready_i,
    output logic [ADDR_WIDTH-1:0] drain_addr_o,
    output logic [DATA_WIDTH-1:0] drain_data_o,
    output logic [BYTES-1:0]      drain_be_o,
    input  logic                  search_valid_i,
    input  logic [ADDR_WIDTH-1:0] search_addr_i,
    input  logic [BYTES-1:0]      search_be_i,
    output logic                  search_hit_o,
    output logic                  search_full_hit_o,
    output logic [DATA_WIDTH-1:0] search_data_o,
    output logic [BYTES-1:0]      search_fwd_be_o,
    input  logic                  flush_req_i,
    output logic                  flush_done_o,
    output logic [CW-1:0]         count_o,
    output logic                  empty_o,
    output logic                  full_o
);

    logic [PW-1:0]          head_q, head_d, tail_q, tail_d, tail_m1;
    logic [CW-1:0]          count_q, count_d;
    store_sb_entry_t        entries_q [NUM_ENTRIES];
    logic                   pop, coalesce, push_fire, alloc;
    logic [NUM_ENTRIES-1:0] valid;
    logic [DATA_WIDTH-1:0]  fwd_data;
    logic [BYTES-1:0]       fwd_be;

    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == CW'(NUM_ENTRIES));
    assign count_o       = count_q;
    assign flush_done_o  = flush_req_i && empty_o;

    assign drain_valid_o = !empty_o;
    assign drain_addr_o  = entries_q[head_q].addr;
    assign drain_data_o  = entries_q[head_q].data;
    assign drain_be_o    = entries_q[head_q].be;
    assign pop           = drain_valid_o && drain_ready_i;

    // The youngest entry is also the head when count is 1; merging into it while it drains would lose the bytes.
    assign tail_m1   = tail_q - PW'(1);
    assign coalesce  = COALESCE_EN && push_valid_i && !empty_o
                       && sb_same_word(entries_q[tail_m1].addr, push_addr_i)
                       && !(pop && count_q == CW'(1));
    assign push_ready_o = !flush_req_i && (!full_o || coalesce);
    assign push_fire    = push_valid_i && push_ready_o;
    assign alloc        = push_fire && !coalesce;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(alloc) - CW'(pop);
        if (pop) begin
            head_d = head_q + PW'(1);
        end
        if (alloc) begin
            tail_d = tail_q + PW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage carries no reset; occupancy is defined solely by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (alloc) begin
            entries_q[tail_q] <= '{addr: sb_word_align(push_addr_i), data: push_data_i, be: push_be_i};
        end else if (push_fire && coalesce) begin
            for (int b = 0; b < BYTES; b++) begin
                if (push_be_i[b]) begin
                    entries_q[tail_m1].data[8*b +: 8] <= push_data_i[8*b +: 8];
                end
            end
            entries_q[tail_m1].be <= entries_q[tail_m1].be | push_be_i;
        end
    end

    always_comb begin
        logic [PW-1:0] rel;
        valid = '0;
        rel   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            rel      = PW'(i) - head_q;
            valid[i] = ({1'b0, rel} < count_q);
        end
    end

    store_sb_fwd_select #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_fwd_select (
        .entries_i (entries_q),
        .valid_i   (valid),
        .head_i    (head_q),
        .addr_i    (search_addr_i),
        .data_o    (fwd_data),
        .fwd_be_o  (fwd_be)
    );

    assign search_fwd_be_o   = search_valid_i ? (fwd_be & search_be_i) : '0;
    assign search_hit_o      = |search_fwd_be_o;
    assign search_full_hit_o = search_valid_i && (search_fwd_be_o == search_be_i) && (search_be_i != '0);

    always_comb begin
        search_data_o = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (search_fwd_be_o[b]) begin
                search_data_o[8*b +: 8] = fwd_data[8*b +: 8];
            end
        end
    end

endmodule
